// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// ALU operation classes, ALU control codes and datapath mux selects.
package rv32_ctrl_pkg;

  localparam int STATE_W   = 4;
  localparam int ALUCTRL_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Opcodes without an immediate (R-type, unknown) fall back to the I format.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/rv32_alu_decoder.sv
// Maps the FSM's ALU operation class plus funct3/funct7b5/op[5] to alu_control.
module rv32_alu_decoder
  import rv32_ctrl_pkg::*;
(
  input  alu_op_t                i_alu_op,
  input  logic [2:0]             i_funct3,
  input  logic                   i_funct7b5,
  input  logic                   i_op5,
  output logic [ALUCTRL_W-1:0]   o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // Only R-type (op[5]=1) subtracts; addi ignores instr[30].
          3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core (Moore outputs, state on dbg_state).
// Optional memory wait states are enabled by defining MEM_WAIT_EN (adds mem_ready).
module rv32_multicycle_ctrl
  import rv32_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef MEM_WAIT_EN
  input  logic                  mem_ready,
`endif
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  zero,
  output logic [1:0]            imm_src,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALUCTRL_W-1:0]  alu_control,
  output logic                  reg_write,
  output logic                  illegal_op,
  output logic [STATE_W-1:0]    dbg_state
);

  state_t  r_state;
  state_t  w_next;
  alu_op_t w_alu_op;
  logic    w_mem_ready;
  logic    w_pc_update;
  logic    w_branch;
  logic    w_ir_write;
  logic    w_mem_write;
  logic    w_reg_write;

`ifdef MEM_WAIT_EN
  assign w_mem_ready = mem_ready;
`else
  assign w_mem_ready = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = S_FETCH;
    w_alu_op    = ALUOP_ADD;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    illegal_op  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_write  = w_mem_ready;
        w_pc_update = w_mem_ready;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_FOUR;
        result_src  = RES_ALURESULT;
        w_next      = w_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute PC+imm into ALUOut for beq/jal.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
          default: begin
            illegal_op = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        w_next    = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        w_next  = w_mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src  = RES_READDATA;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
        w_next      = w_mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        w_alu_op  = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        w_alu_op  = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        result_src  = RES_ALUOUT;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        w_alu_op   = ALUOP_SUB;
        result_src = RES_ALUOUT;
        w_branch   = 1'b1;
        w_next     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a   = SRCA_OLDPC;
        alu_src_b   = SRCB_FOUR;
        result_src  = RES_ALUOUT;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
  end

  rv32_alu_decoder u_alu_dec (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .i_op5         (op[5]),
    .o_alu_control (alu_control)
  );

  // Write enables are killed combinationally so nothing commits while reset is held.
  assign pc_write  = rst_n & (w_pc_update | (w_branch & zero));
  assign ir_write  = rst_n & w_ir_write;
  assign mem_write = rst_n & w_mem_write;
  assign reg_write = rst_n & w_reg_write;
  assign imm_src   = imm_src_of(op);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Randomized scoreboard bench for rv32_multicycle_ctrl: per-instruction cycle
// sequences are queued by the driver and compared each cycle by a monitor.
module tb_rv32_multicycle_ctrl;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] imm_src;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control;
  logic [3:0] dbg_state;

  rv32_multicycle_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef MEM_WAIT_EN
    .mem_ready   (mem_ready),
`endif
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .imm_src     (imm_src),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .reg_write   (reg_write),
    .illegal_op  (illegal_op),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  logic [20:0] exp_q[$];
  string       tag_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b0;
  int          force_wait = -1;

  logic [6:0] p_op;
  logic [2:0] p_f3;
  logic       p_f7;
  logic       p_zero;

  // {state, imm_src, pc_write, adr_src, mem_write, ir_write, result_src, a, b, alu_control, reg_write, illegal_op}
  function automatic logic [20:0] mk(input int st, input logic [1:0] imm, input logic pcw,
                                     input logic adr, input logic mw, input logic irw,
                                     input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] alu, input logic rw, input logic il);
    logic [3:0] s;
    s = st[3:0];
    return {s, imm, pcw, adr, mw, irw, rs, a, b, alu, rw, il};
  endfunction

  function automatic logic [2:0] exp_funct(input logic [2:0] f3, input logic f7, input logic op5);
    case (f3)
      3'b000:  return (op5 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int mem_waits();
`ifdef MEM_WAIT_EN
    if (force_wait >= 0) return force_wait;
    return $urandom_range(0, 2);
`else
    return 0;
`endif
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
           (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111);
  endfunction

  // One clock cycle of stimulus plus its expected outputs.
  task automatic cyc(input logic [20:0] r, input logic mr, input bit apply, input string tag);
    @(posedge clk);
    #1;
    if (apply) begin
      op = p_op; funct3 = p_f3; funct7b5 = p_f7; zero = p_zero;
    end
    mem_ready = mr;
    exp_q.push_back(r);
    tag_q.push_back(tag);
    mon_en = 1'b1;
  endtask

  task automatic run_instr(input int kind, input logic [2:0] f3, input logic f7, input logic z,
                           input logic [6:0] ill_op, input bit skip_fetch, input bit abort);
    logic [1:0] imm;
    logic [2:0] alu;
    bit         first;
    int         w;
    first = 1'b1;
    case (kind)
      K_LW:  begin p_op = 7'b0000011; imm = 2'b00; end
      K_SW:  begin p_op = 7'b0100011; imm = 2'b01; end
      K_R:   begin p_op = 7'b0110011; imm = 2'b00; end
      K_I:   begin p_op = 7'b0010011; imm = 2'b00; end
      K_BEQ: begin p_op = 7'b1100011; imm = 2'b10; end
      K_JAL: begin p_op = 7'b1101111; imm = 2'b11; end
      default: begin p_op = ill_op; imm = 2'b00; end
    endcase
    p_f3 = f3; p_f7 = f7; p_zero = z;
    alu = exp_funct(f3, f7, p_op[5]);
    if (!skip_fetch) begin
      w = mem_waits();
      for (int i = 0; i < w; i++) begin
        cyc(mk(0, imm, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0), 1'b0, first, "fetch_wait");
        first = 1'b0;
      end
      cyc(mk(0, imm, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0), 1'b1, first, "fetch");
      first = 1'b0;
    end
    cyc(mk(1, imm, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, kind == K_ILL),
        1'($urandom_range(0, 1)), first, "decode");
    case (kind)
      K_LW, K_SW: begin
        cyc(mk(2, imm, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0), 1'($urandom_range(0, 1)), 0, "memadr");
        if (abort) begin
          @(posedge clk);
          #1;
          rst_n = 1'b0;
          exp_q.push_back(mk(0, imm, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0));
          tag_q.push_back("reset_mid");
          @(negedge clk);
          #2;
          rst_n = 1'b1;
          return;
        end
        w = mem_waits();
        for (int i = 0; i <= w; i++) begin
          if (kind == K_LW)
            cyc(mk(3, imm, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0), i == w, 0, "memread");
          else
            cyc(mk(5, imm, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0), i == w, 0, "memwrite");
        end
        if (kind == K_LW)
          cyc(mk(4, imm, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0), 1'($urandom_range(0, 1)), 0, "memwb");
      end
      K_R, K_I: begin
        if (kind == K_R)
          cyc(mk(6, imm, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 0, 0), 1'($urandom_range(0, 1)), 0, "execr");
        else
          cyc(mk(8, imm, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 0, 0), 1'($urandom_range(0, 1)), 0, "execi");
        cyc(mk(7, imm, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0), 1'($urandom_range(0, 1)), 0, "aluwb");
      end
      K_BEQ:
        cyc(mk(10, imm, z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, 0), 1'($urandom_range(0, 1)), 0, "beq");
      K_JAL: begin
        cyc(mk(9, imm, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0), 1'($urandom_range(0, 1)), 0, "jal");
        cyc(mk(7, imm, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0), 1'($urandom_range(0, 1)), 0, "aluwb");
      end
      default: ;
    endcase
  endtask

  function automatic logic [6:0] rand_illegal();
    logic [6:0] o;
    do o = 7'($urandom_range(0, 127)); while (is_legal(o));
    return o;
  endfunction

  always @(negedge clk) begin
    logic [20:0] act;
    logic [20:0] e;
    string       t;
    if (mon_en) begin
      act = {dbg_state, imm_src, pc_write, adr_src, mem_write, ir_write, result_src,
             alu_src_a, alu_src_b, alu_control, reg_write, illegal_op};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL underflow: dut=%h expected nothing queued (t=%0t)", act, $time);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: got %h want %h (state %0d want %0d) t=%0t", t, act, e,
                   act[20:17], e[20:17], $time);
        end
      end
    end
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    int k;
    rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0));
    tag_q.push_back("reset");
    mon_en = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    run_instr(K_LW,  3'b010, 1'b0, 1'b0, 7'd0, 1, 0);
    run_instr(K_SW,  3'b010, 1'b0, 1'b0, 7'd0, 0, 0);
    run_instr(K_R,   3'b000, 1'b1, 1'b0, 7'd0, 0, 0);
    run_instr(K_R,   3'b000, 1'b0, 1'b1, 7'd0, 0, 0);
    run_instr(K_I,   3'b000, 1'b1, 1'b0, 7'd0, 0, 0);
    run_instr(K_R,   3'b110, 1'b0, 1'b0, 7'd0, 0, 0);
    run_instr(K_I,   3'b111, 1'b0, 1'b0, 7'd0, 0, 0);
    run_instr(K_R,   3'b010, 1'b0, 1'b0, 7'd0, 0, 0);
    run_instr(K_BEQ, 3'b000, 1'b0, 1'b1, 7'd0, 0, 0);
    run_instr(K_BEQ, 3'b000, 1'b0, 1'b0, 7'd0, 0, 0);
    run_instr(K_JAL, 3'b000, 1'b0, 1'b0, 7'd0, 0, 0);
    run_instr(K_ILL, 3'b000, 1'b0, 1'b0, 7'd0, 0, 0);
`ifdef MEM_WAIT_EN
    force_wait = 3;
    run_instr(K_LW, 3'b010, 1'b0, 1'b0, 7'd0, 0, 0);
    run_instr(K_SW, 3'b010, 1'b0, 1'b0, 7'd0, 0, 0);
    force_wait = -1;
`endif
    run_instr(K_LW, 3'b010, 1'b0, 1'b0, 7'd0, 0, 1);
    run_instr(K_R,  3'b111, 1'b0, 1'b0, 7'd0, 1, 0);

    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 6);
      run_instr(k, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                rand_illegal(), 0, 0);
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected cycles unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
